// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// a constant-function clog2 used to size the bit counter.
package bsa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Never returns less than 1 so a counter declared from it always has a bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// Single-bit full adder cell shared across the arithmetic datapaths.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder built from one full adder and a registered carry,
// consuming operands LSB-first at one bit per clock behind valid/ready.
module bit_serial_adder
    import bsa_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c
);

    localparam int unsigned CW = clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;
    logic             accept;

    full_adder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c_in  (carry),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign accept   = in_valid && (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last_bit)  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            out_sum <= '0;
            out_c   <= 1'b0;
        end else if (accept) begin
            a_sr  <= in_a;
            b_sr  <= in_b;
            carry <= in_c;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
            carry  <= fa_cout;
            // Counter stops at WIDTH-1; the FSM leaves RUN on that edge.
            if (last_bit) begin
                out_sum <= {fa_sum, sum_sr[WIDTH-1:1]};
                out_c   <= fa_cout;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder at WIDTH=8 (directed + random) and WIDTH=16 (random).
module tb_bit_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid8 = 1'b0, in_ready8, in_c8 = 1'b0;
    logic [7:0]  in_a8 = '0, in_b8 = '0, out_sum8;
    logic        out_valid8, out_ready8 = 1'b1, out_c8;

    logic        in_valid16 = 1'b0, in_ready16, in_c16 = 1'b0;
    logic [15:0] in_a16 = '0, in_b16 = '0, out_sum16;
    logic        out_valid16, out_ready16 = 1'b1, out_c16;

    logic [8:0]  q8[$];
    logic [16:0] q16[$];
    int unsigned acc8 = 0, acc16 = 0;
    int unsigned n_cmp = 0, n_bad = 0;
    logic        mon_en = 1'b0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_c(in_c8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_sum(out_sum8), .out_c(out_c8)
    );

    bit_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .in_a(in_a16), .in_b(in_b16), .in_c(in_c16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out_sum(out_sum16), .out_c(out_c16)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change only at posedge+1, so the negedge view equals what the next posedge samples.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (in_valid8 && in_ready8) begin
                q8.push_back({1'b0, in_a8} + {1'b0, in_b8} + {8'd0, in_c8});
                acc8++;
            end
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) check_eq("dup8", 32'd1, 32'd0);
                else check_eq("res8", {23'd0, out_c8, out_sum8}, {23'd0, q8.pop_front()});
            end
            if (in_valid16 && in_ready16) begin
                q16.push_back({1'b0, in_a16} + {1'b0, in_b16} + {16'd0, in_c16});
                acc16++;
            end
            if (out_valid16 && out_ready16) begin
                if (q16.size() == 0) check_eq("dup16", 32'd1, 32'd0);
                else check_eq("res16", {15'd0, out_c16, out_sum16}, {15'd0, q16.pop_front()});
            end
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int unsigned n;
        n = 0;
        while (!in_ready8 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready8) check_eq("ready_timeout8", 32'd0, 32'd1);
        in_valid8 = 1'b1; in_a8 = a; in_b8 = b; in_c8 = c;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        in_a8 = ~a; in_b8 = ~b; in_c8 = ~c;
    endtask

    // Returns once out_valid8 is seen; lat = clock edges from accept edge.
    task automatic wait_out8(output int unsigned lat);
        lat = 1;
        @(posedge clk); #1;
        while (!out_valid8 && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid8) check_eq("valid_timeout8", 32'd0, 32'd1);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [8:0] exp, input string tag);
        int unsigned lat;
        issue8(a, b, c);
        wait_out8(lat);
        check_eq({tag, "_lat"}, lat, 32'd8);
        check_eq({tag, "_res"}, {23'd0, out_c8, out_sum8}, {23'd0, exp});
        @(posedge clk); #1;
    endtask

    task automatic rand8;
        int unsigned cyc;
        cyc = 0;
        while (acc8 < 500 && cyc < 40000) begin
            in_valid8  = ($urandom_range(3) != 0);
            in_a8      = 8'($urandom);
            in_b8      = 8'($urandom);
            in_c8      = 1'($urandom);
            out_ready8 = ($urandom_range(2) != 0);
            @(posedge clk); #1; cyc++;
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        if (acc8 < 500) check_eq("rand8_budget", acc8, 32'd500);
    endtask

    task automatic rand16;
        int unsigned cyc;
        cyc = 0;
        while (acc16 < 500 && cyc < 40000) begin
            in_valid16  = ($urandom_range(3) != 0);
            in_a16      = 16'($urandom);
            in_b16      = 16'($urandom);
            in_c16      = 1'($urandom);
            out_ready16 = ($urandom_range(2) != 0);
            @(posedge clk); #1; cyc++;
        end
        in_valid16 = 1'b0; out_ready16 = 1'b1;
        if (acc16 < 500) check_eq("rand16_budget", acc16, 32'd500);
    endtask

    initial begin
        logic [7:0] hs;
        logic       hc;
        int unsigned lat;

        #12;
        check_eq("rst_in_ready8",  {31'd0, in_ready8},  32'd1);
        check_eq("rst_out_valid8", {31'd0, out_valid8}, 32'd0);
        check_eq("rst_out8",       {23'd0, out_c8, out_sum8}, 32'd0);
        check_eq("rst_out16",      {15'd0, out_c16, out_sum16}, 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        run8(8'h5A, 8'h33, 1'b0, 9'h08D, "t1");
        run8(8'hFF, 8'h01, 1'b0, 9'h100, "t2");
        run8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "t3a");
        run8(8'h00, 8'h00, 1'b0, 9'h000, "t3b");

        // Stall in DONE with out_ready low.
        out_ready8 = 1'b0;
        issue8(8'hC3, 8'h5E, 1'b1);
        wait_out8(lat);
        hs = out_sum8; hc = out_c8;
        check_eq("stall_res", {23'd0, hc, hs}, 32'h122);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check_eq("stall_valid", {31'd0, out_valid8}, 32'd1);
            check_eq("stall_ready", {31'd0, in_ready8}, 32'd0);
            check_eq("stall_hold", {23'd0, out_c8, out_sum8}, {23'd0, hc, hs});
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        check_eq("release_ready", {31'd0, in_ready8}, 32'd1);
        check_eq("release_valid", {31'd0, out_valid8}, 32'd0);

        // Asynchronous reset in the middle of RUN.
        issue8(8'h77, 8'h66, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", {31'd0, out_valid8}, 32'd0);
        check_eq("arst_ready", {31'd0, in_ready8}, 32'd1);
        check_eq("arst_out",   {23'd0, out_c8, out_sum8}, 32'd0);
        q8.delete();
        @(posedge clk); #3;
        check_eq("arst_hold_valid", {31'd0, out_valid8}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run8(8'h10, 8'h20, 1'b0, 9'h030, "t5");

        fork
            rand8();
            rand16();
        join

        for (int k = 0; k < 100 && (q8.size() != 0 || q16.size() != 0); k++) begin
            @(posedge clk); #1;
        end
        check_eq("lost8",  q8.size(),  32'd0);
        check_eq("lost16", q16.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
